// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, requester IDs and the
// default starvation limit.
package mem_arb_pkg;

  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_I = 3'd1,
    S_RD_D = 3'd2,
    S_WR_D = 3'd3,
    S_RESP = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_IFU  = 2'd1,
    ID_LD   = 2'd2,
    ID_ST   = 2'd3
  } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: store > load > fetch, unless fetch has
// been starved for STARVE_LIM data grants, in which case fetch wins.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int CNT_W      = 3
) (
  input  logic             i_ifu_req,
  input  logic             i_rd_req,
  input  logic             i_wr_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic [1:0]       o_pick
);

  logic w_starved;

  assign w_starved = i_ifu_req && (i_starve_cnt == CNT_W'(STARVE_LIM));

  always_comb begin
    o_pick = ID_NONE;
    if (w_starved)      o_pick = ID_IFU;
    else if (i_wr_req)  o_pick = ID_ST;
    else if (i_rd_req)  o_pick = ID_LD;
    else if (i_ifu_req) o_pick = ID_IFU;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one RAM port between fetch, load and store.
//   state  | meaning
//   IDLE   | no transaction; arbitrate pending requests
//   RD_I   | fetch read in flight, ram_rd_en held until ram_rd_valid
//   RD_D   | load read in flight, ram_rd_en held until ram_rd_valid
//   WR_D   | store in flight, ram_wr_en held until ram_wr_done
//   RESP   | finish pulse cycle; back to IDLE next
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_finish,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                mem_rd_req,
  input  logic [ADDR_W-1:0]   mem_rd_addr,
  output logic                mem_rd_finish,
  output logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_wr_req,
  input  logic [ADDR_W-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_wr_data,
  input  logic [DATA_W/8-1:0] mem_wr_strb,
  output logic                mem_wr_finish,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic                ram_rd_valid,
  input  logic [DATA_W-1:0]   ram_rd_data,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [DATA_W-1:0]   ram_wr_data,
  output logic [DATA_W/8-1:0] ram_wr_strb,
  input  logic                ram_wr_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  arb_state_t       r_state;
  req_id_t          r_id;
  logic [CNT_W-1:0] r_starve;
  logic [1:0]       w_pick;

  mem_arb_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .i_ifu_req    (ifu_req),
    .i_rd_req     (mem_rd_req),
    .i_wr_req     (mem_wr_req),
    .i_starve_cnt (r_starve),
    .o_pick       (w_pick)
  );

  assign busy = (r_state != S_IDLE);

  // Counts data grants that overtook a waiting fetch; any gap in ifu_req resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!ifu_req) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_pick == ID_IFU) begin
        r_starve <= '0;
      end else if ((w_pick == ID_LD || w_pick == ID_ST) && r_starve != CNT_W'(STARVE_LIM)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_id          <= ID_NONE;
      ifu_finish    <= 1'b0;
      ifu_rdata     <= '0;
      mem_rd_finish <= 1'b0;
      mem_rd_data   <= '0;
      mem_wr_finish <= 1'b0;
      ram_rd_en     <= 1'b0;
      ram_rd_addr   <= '0;
      ram_wr_en     <= 1'b0;
      ram_wr_addr   <= '0;
      ram_wr_data   <= '0;
      ram_wr_strb   <= '0;
    end else begin
      ifu_finish    <= 1'b0;
      mem_rd_finish <= 1'b0;
      mem_wr_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_id <= req_id_t'(w_pick);
          case (w_pick)
            ID_IFU: begin
              r_state     <= S_RD_I;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= ifu_addr;
            end
            ID_LD: begin
              r_state     <= S_RD_D;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= mem_rd_addr;
            end
            ID_ST: begin
              r_state     <= S_WR_D;
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= mem_wr_addr;
              ram_wr_data <= mem_wr_data;
              ram_wr_strb <= mem_wr_strb;
            end
            default: ;
          endcase
        end
        S_RD_I, S_RD_D: begin
          if (ram_rd_valid) begin
            r_state     <= S_RESP;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            if (r_id == ID_IFU) begin
              ifu_finish <= 1'b1;
              ifu_rdata  <= ram_rd_data;
            end else begin
              mem_rd_finish <= 1'b1;
              mem_rd_data   <= ram_rd_data;
            end
          end
        end
        S_WR_D: begin
          if (ram_wr_done) begin
            r_state       <= S_RESP;
            ram_wr_en     <= 1'b0;
            ram_wr_addr   <= '0;
            ram_wr_data   <= '0;
            ram_wr_strb   <= '0;
            mem_wr_finish <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_id    <= ID_NONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
